// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-beat data-memory access stage. Latches an ALU effective
//               address plus store data / funct3, screens for illegal and
//               misaligned accesses, runs one REQ/ACK memory transaction with
//               an optional timeout, and formats load data (lane extract and
//               sign/zero extension) or store data (lane replication and
//               byte strobes). Completion is a one-cycle DONE pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        LSU_START_i,
    input  logic        LSU_WE_i,
    input  logic [2:0]  LSU_FUNCT3_i,
    input  logic [31:0] LSU_ADDR_i,
    input  logic [31:0] LSU_WDATA_i,
    output logic [31:0] LSU_RDATA_o,
    output logic        LSU_DONE_o,
    output logic        LSU_BUSY_o,
    output logic [1:0]  LSU_ERR_o,
    output logic        MEM_REQ_o,
    output logic        MEM_WE_o,
    output logic [31:0] MEM_ADDR_o,
    output logic [31:0] MEM_WDATA_o,
    output logic [3:0]  MEM_WSTRB_o,
    input  logic        MEM_ACK_i,
    input  logic [31:0] MEM_RDATA_i
);

    // Counter is wide enough to hold the limit itself; a zero limit disables it.
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W:0] c_TMO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);
    localparam logic [CNT_W:0] c_CNT_ONE   = (CNT_W + 1)'(1);

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_W  = 3'b010;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_ALIGN = 2'b01;
    localparam logic [1:0] c_ERR_TMO   = 2'b10;
    localparam logic [1:0] c_ERR_ILL   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_illegal;
    logic             w_misaligned;
    logic [CNT_W:0]   w_cnt_next;
    logic             w_timeout;
    logic [15:0]      w_rd_lane;
    logic [31:0]      w_load_val;
    logic [3:0]       w_wstrb;
    logic [31:0]      w_wdata;
    logic             w_in_req;

    // Screen the incoming request: illegal encodings first, then alignment.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        if (LSU_WE_i) begin
            w_illegal = (LSU_FUNCT3_i > c_F3_W);
        end else begin
            w_illegal = !(LSU_FUNCT3_i inside {c_F3_B, c_F3_H, c_F3_W, c_F3_BU, c_F3_HU});
        end
        case (LSU_FUNCT3_i)
            c_F3_H, c_F3_HU: w_misaligned = LSU_ADDR_i[0];
            c_F3_W:          w_misaligned = |LSU_ADDR_i[1:0];
            default:         w_misaligned = 1'b0;
        endcase
    end

    assign w_cnt_next = {1'b0, cnt_q} + c_CNT_ONE;
    assign w_timeout  = (TIMEOUT_CYCLES != 0) && (w_cnt_next == c_TMO_LIMIT);
    assign w_in_req   = (state_q == ST_REQ);

    // Load formatting: shift the addressed lane down, then extend per funct3.
    always_comb begin
        w_rd_lane = 16'(MEM_RDATA_i >> {addr_q[1:0], 3'b000});
        case (funct3_q)
            c_F3_B:  w_load_val = {{24{w_rd_lane[7]}}, w_rd_lane[7:0]};
            c_F3_BU: w_load_val = {24'd0, w_rd_lane[7:0]};
            c_F3_H:  w_load_val = {{16{w_rd_lane[15]}}, w_rd_lane};
            c_F3_HU: w_load_val = {16'd0, w_rd_lane};
            default: w_load_val = MEM_RDATA_i;
        endcase
    end

    // Store formatting: replicate the low bytes into every lane, strobe the target.
    always_comb begin
        case (funct3_q)
            c_F3_B: begin
                w_wstrb = 4'b0001 << addr_q[1:0];
                w_wdata = {4{wdata_q[7:0]}};
            end
            c_F3_H: begin
                w_wstrb = 4'b0011 << {addr_q[1], 1'b0};
                w_wdata = {2{wdata_q[15:0]}};
            end
            default: begin
                w_wstrb = 4'b1111;
                w_wdata = wdata_q;
            end
        endcase
    end

    // Next-state and datapath update for the IDLE -> REQ -> DONE sequence.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (LSU_START_i) begin
                    we_d     = LSU_WE_i;
                    funct3_d = LSU_FUNCT3_i;
                    addr_d   = LSU_ADDR_i;
                    wdata_d  = LSU_WDATA_i;
                    rdata_d  = 32'd0;
                    cnt_d    = '0;
                    if (w_illegal) begin
                        err_d   = c_ERR_ILL;
                        state_d = ST_DONE;
                    end else if (w_misaligned) begin
                        err_d   = c_ERR_ALIGN;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = c_ERR_OK;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // An ack on the limit cycle still completes normally.
                if (MEM_ACK_i) begin
                    if (!we_q) begin
                        rdata_d = w_load_val;
                    end
                    state_d = ST_DONE;
                end else if (w_timeout) begin
                    err_d   = c_ERR_TMO;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = w_cnt_next[CNT_W-1:0];
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 2'd0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign LSU_RDATA_o = rdata_q;
    assign LSU_ERR_o   = err_q;
    assign LSU_DONE_o  = (state_q == ST_DONE);
    assign LSU_BUSY_o  = (state_q != ST_IDLE);

    // Memory-side outputs are driven only while a request is outstanding.
    assign MEM_REQ_o   = w_in_req;
    assign MEM_WE_o    = w_in_req & we_q;
    assign MEM_ADDR_o  = w_in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign MEM_WDATA_o = (w_in_req & we_q) ? w_wdata : 32'd0;
    assign MEM_WSTRB_o = (w_in_req & we_q) ? w_wstrb : 4'd0;

endmodule
`default_nettype wire
